pipe_main_control: RTL

Pipelined main control unit for the MIPS datapath. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB stage registers. It detects load-use hazards and freezes the pipeline while data memory is not ready. Branch flushes squash the ID/EX and EX/MEM stages. It extends the single-stage decoder with bne, byte loads and byte/half stores, and pipelined bubble handling.

---
 rtl/pipe_main_control.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_main_control.sv
// Pipelined main control unit for the MIPS datapath.
// Decodes the ID-stage opcode into a control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB stage registers. It stalls on load-use hazards,
// freezes while data memory is busy, and squashes EX and MEM on branch flush.
module pipe_main_control #(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned REG_W     = 5,
  parameter bit          EN_HAZARD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [OP_W-1:0]  id_opcode_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             flush_i,
  input  logic             mem_ready_i,
  output logic             stall_if_id_o,
  output logic             ex_valid_o,
  output logic             ex_reg_dest_o,
  output logic             ex_alu_src_o,
  output logic [1:0]       ex_alu_op_o,
  output logic             ex_illegal_o,
  output logic             mem_branch_o,
  output logic             mem_branch_ne_o,
  output logic             mem_mem_read_o,
  output logic             mem_mem_write_o,
  output logic [1:0]       mem_width_o,
  output logic             mem_signed_o,
  output logic             wb_mem_to_reg_o,
  output logic             wb_reg_write_o
);

  // Full control bundle held in ID/EX.
  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_dest;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] width;
    logic       signed_ld;
    logic       mem_to_reg;
    logic       reg_write;
  } ex_ctrl_t;

  // Subset still needed once the instruction has left EX.
  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] width;
    logic       signed_ld;
    logic       mem_to_reg;
    logic       reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  // Width encodings for loads and stores.
  localparam logic [1:0] WidthWord = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;
  localparam logic [1:0] WidthByte = 2'b10;

  // ALU operation encodings.
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluImm   = 2'b11;

  ex_ctrl_t         id_ex_q, id_ex_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  mem_ctrl_t        ex_mem_q, ex_mem_d;
  wb_ctrl_t         mem_wb_q, mem_wb_d;

  ex_ctrl_t   dec;
  logic       rt_src;
  logic [7:0] op8;
  logic       mem_wait;
  logic       load_use;
  mem_ctrl_t  ex_fwd;
  wb_ctrl_t   mem_fwd;

  // Decode the ID opcode into a fresh control bundle and flag rt as a source.
  always_comb begin
    op8         = 8'(id_opcode_i);
    dec         = '0;
    dec.valid   = 1'b1;
    rt_src      = 1'b0;
    case (op8)
      8'h00: begin
        dec.reg_dest  = 1'b1;
        dec.alu_op    = AluFunct;
        dec.reg_write = 1'b1;
        rt_src        = 1'b1;
      end
      8'h08: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = AluImm;
        dec.reg_write = 1'b1;
      end
      8'h23, 8'h21, 8'h25, 8'h20, 8'h24: begin
        dec.alu_src    = 1'b1;
        dec.alu_op     = AluAdd;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        case (op8)
          8'h21:   begin dec.width = WidthHalf; dec.signed_ld = 1'b1; end
          8'h25:   begin dec.width = WidthHalf; dec.signed_ld = 1'b0; end
          8'h20:   begin dec.width = WidthByte; dec.signed_ld = 1'b1; end
          8'h24:   begin dec.width = WidthByte; dec.signed_ld = 1'b0; end
          default: begin dec.width = WidthWord; dec.signed_ld = 1'b0; end
        endcase
      end
      8'h2B, 8'h29, 8'h28: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = AluAdd;
        dec.mem_write = 1'b1;
        rt_src        = 1'b1;
        case (op8)
          8'h29:   dec.width = WidthHalf;
          8'h28:   dec.width = WidthByte;
          default: dec.width = WidthWord;
        endcase
      end
      8'h04, 8'h05: begin
        dec.branch    = 1'b1;
        dec.branch_ne = op8[0];
        dec.alu_op    = AluSub;
        rt_src        = 1'b1;
      end
      default: begin
        // Unknown opcode: no side effects, but still tracked as an instruction.
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Hazard detection and the values each stage would take when advancing.
  always_comb begin
    mem_wait = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write) & ~mem_ready_i;
    load_use = EN_HAZARD & id_valid_i & id_ex_q.valid & id_ex_q.mem_read &
               (ex_rt_q != '0) &
               ((ex_rt_q == id_rs_i) | (rt_src & (ex_rt_q == id_rt_i)));

    ex_fwd.valid      = id_ex_q.valid;
    ex_fwd.branch     = id_ex_q.branch;
    ex_fwd.branch_ne  = id_ex_q.branch_ne;
    ex_fwd.mem_read   = id_ex_q.mem_read;
    ex_fwd.mem_write  = id_ex_q.mem_write;
    ex_fwd.width      = id_ex_q.width;
    ex_fwd.signed_ld  = id_ex_q.signed_ld;
    ex_fwd.mem_to_reg = id_ex_q.mem_to_reg;
    ex_fwd.reg_write  = id_ex_q.reg_write;

    mem_fwd.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_fwd.reg_write  = ex_mem_q.reg_write;

    stall_if_id_o = mem_wait | (load_use & ~flush_i);
  end

  // Next-state selection: freeze beats flush, flush beats load-use bubble.
  always_comb begin
    id_ex_d  = id_ex_q;
    ex_rt_d  = ex_rt_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (mem_wait) begin
      // Hold every stage until memory completes.
    end else if (flush_i) begin
      id_ex_d  = '0;
      ex_rt_d  = '0;
      ex_mem_d = '0;
      mem_wb_d = mem_fwd;
    end else begin
      ex_mem_d = ex_fwd;
      mem_wb_d = mem_fwd;
      if (!load_use && id_valid_i) begin
        id_ex_d = dec;
        ex_rt_d = id_rt_i;
      end else begin
        id_ex_d = '0;
        ex_rt_d = '0;
      end
    end
  end

  // Stage registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q  <= '0;
      ex_rt_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_rt_q  <= ex_rt_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Stage outputs come straight from the registers.
  always_comb begin
    ex_valid_o      = id_ex_q.valid;
    ex_reg_dest_o   = id_ex_q.reg_dest;
    ex_alu_src_o    = id_ex_q.alu_src;
    ex_alu_op_o     = id_ex_q.alu_op;
    ex_illegal_o    = id_ex_q.illegal;
    mem_branch_o    = ex_mem_q.branch;
    mem_branch_ne_o = ex_mem_q.branch_ne;
    mem_mem_read_o  = ex_mem_q.mem_read;
    mem_mem_write_o = ex_mem_q.mem_write;
    mem_width_o     = ex_mem_q.width;
    mem_signed_o    = ex_mem_q.signed_ld;
    wb_mem_to_reg_o = mem_wb_q.mem_to_reg;
    wb_reg_write_o  = mem_wb_q.reg_write;
  end

endmodule
